// File: rtl/regmap_axil.sv
// regmap_axil: AXI4-Lite CSR block (RW, RO, trigger, W1C status); define REGMAP_AXIL_IRQ_EN for mask register and irq output
module regmap_axil #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int N_RW = 4,
   parameter int N_RO = 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [ADDR_WIDTH-1:0]        cbus_awaddr,
   input  logic                         cbus_awvalid,
   output logic                         cbus_awready,
   input  logic [DATA_WIDTH-1:0]        cbus_wdata,
   input  logic [DATA_WIDTH/8-1:0]      cbus_wstrb,
   input  logic                         cbus_wvalid,
   output logic                         cbus_wready,
   output logic [1:0]                   cbus_bresp,
   output logic                         cbus_bvalid,
   input  logic                         cbus_bready,
   input  logic [ADDR_WIDTH-1:0]        cbus_araddr,
   input  logic                         cbus_arvalid,
   output logic                         cbus_arready,
   output logic [DATA_WIDTH-1:0]        cbus_rdata,
   output logic [1:0]                   cbus_rresp,
   output logic                         cbus_rvalid,
   input  logic                         cbus_rready,
   output logic [N_RW*DATA_WIDTH-1:0]   rw_q,
   input  logic [N_RO*DATA_WIDTH-1:0]   ro_d,
   output logic [DATA_WIDTH-1:0]        trig_pulse,
`ifdef REGMAP_AXIL_IRQ_EN
   output logic                         irq,
`endif
   input  logic [DATA_WIDTH-1:0]        sts_set
);
   localparam int SB = DATA_WIDTH/8;
   localparam int A_TRIG_I = N_RW + N_RO;
   localparam logic [ADDR_WIDTH-1:0] A_RO = ADDR_WIDTH'(N_RW);
   localparam logic [ADDR_WIDTH-1:0] A_TRIG = ADDR_WIDTH'(A_TRIG_I);
   localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(A_TRIG_I + 1);
`ifdef REGMAP_AXIL_IRQ_EN
   localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(A_TRIG_I + 2);
`endif
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   if (A_TRIG_I + 3 > 2**ADDR_WIDTH) begin : g_addr_check
      $error("regmap_axil: register map does not fit in ADDR_WIDTH");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_width_check
      $error("regmap_axil: DATA_WIDTH must be a multiple of 8");
   end

   logic                  aw_full, w_full, commit, wr_ok;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [DATA_WIDTH-1:0] w_data, smask, wm, clr, status, rd_data;
   logic [SB-1:0]         w_strb;
   logic [1:0]            rd_resp;
   logic [DATA_WIDTH-1:0] rw [N_RW];
`ifdef REGMAP_AXIL_IRQ_EN
   logic [DATA_WIDTH-1:0] mask;
`endif

   assign cbus_awready = !aw_full && !cbus_bvalid;
   assign cbus_wready  = !w_full && !cbus_bvalid;
   assign cbus_arready = !cbus_rvalid;
   assign commit = aw_full && w_full;
   assign wm = w_data & smask;
   assign clr = (commit && aw_addr == A_STAT) ? wm : '0;
`ifdef REGMAP_AXIL_IRQ_EN
   assign wr_ok = aw_addr < A_RO || aw_addr == A_TRIG || aw_addr == A_STAT || aw_addr == A_MASK;
`else
   assign wr_ok = aw_addr < A_RO || aw_addr == A_TRIG || aw_addr == A_STAT;
`endif

   genvar i;
   for (i = 0; i < SB; i++) begin : g_smask
      assign smask[i*8 +: 8] = {8{w_strb[i]}};
   end
   for (i = 0; i < N_RW; i++) begin : g_rwq
      assign rw_q[i*DATA_WIDTH +: DATA_WIDTH] = rw[i];
   end

   // read address decode: value and response the AR handshake will capture
   always_comb begin
      rd_data = '0;
      rd_resp = SLVERR;
      for (int k = 0; k < N_RW; k++)
         if (cbus_araddr == ADDR_WIDTH'(k)) begin
            rd_data = rw[k];
            rd_resp = OKAY;
         end
      for (int k = 0; k < N_RO; k++)
         if (cbus_araddr == ADDR_WIDTH'(N_RW + k)) begin
            rd_data = ro_d[k*DATA_WIDTH +: DATA_WIDTH];
            rd_resp = OKAY;
         end
      if (cbus_araddr == A_TRIG) rd_resp = OKAY;
      if (cbus_araddr == A_STAT) begin
         rd_data = status;
         rd_resp = OKAY;
      end
`ifdef REGMAP_AXIL_IRQ_EN
      if (cbus_araddr == A_MASK) begin
         rd_data = mask;
         rd_resp = OKAY;
      end
`endif
   end

   // write channel: independent AW/W buffers, commit when both full, then B response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_full <= 1'b0;
         aw_addr <= '0;
         w_full <= 1'b0;
         w_data <= '0;
         w_strb <= '0;
         cbus_bvalid <= 1'b0;
         cbus_bresp <= OKAY;
      end else begin
         if (cbus_awvalid && cbus_awready) begin
            aw_full <= 1'b1;
            aw_addr <= cbus_awaddr;
         end else if (commit) aw_full <= 1'b0;
         if (cbus_wvalid && cbus_wready) begin
            w_full <= 1'b1;
            w_data <= cbus_wdata;
            w_strb <= cbus_wstrb;
         end else if (commit) w_full <= 1'b0;
         if (commit) begin
            cbus_bvalid <= 1'b1;
            cbus_bresp <= wr_ok ? OKAY : SLVERR;
         end else if (cbus_bvalid && cbus_bready) cbus_bvalid <= 1'b0;
      end
   end

   // register file: strobed RW updates, trigger pulse, W1C status where set wins
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < N_RW; k++) rw[k] <= '0;
         status <= '0;
         trig_pulse <= '0;
`ifdef REGMAP_AXIL_IRQ_EN
         mask <= '0;
`endif
      end else begin
         for (int k = 0; k < N_RW; k++)
            if (commit && aw_addr == ADDR_WIDTH'(k)) rw[k] <= (rw[k] & ~smask) | wm;
         status <= (status & ~clr) | sts_set;
         trig_pulse <= (commit && aw_addr == A_TRIG) ? wm : '0;
`ifdef REGMAP_AXIL_IRQ_EN
         if (commit && aw_addr == A_MASK) mask <= (mask & ~smask) | wm;
`endif
      end
   end

   // read channel: capture decoded value at AR handshake, hold until R handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cbus_rvalid <= 1'b0;
         cbus_rdata <= '0;
         cbus_rresp <= OKAY;
      end else if (cbus_arvalid && cbus_arready) begin
         cbus_rvalid <= 1'b1;
         cbus_rdata <= rd_data;
         cbus_rresp <= rd_resp;
      end else if (cbus_rvalid && cbus_rready) cbus_rvalid <= 1'b0;
   end

`ifdef REGMAP_AXIL_IRQ_EN
   // interrupt: any unmasked status bit, one cycle behind status/mask
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) irq <= 1'b0;
      else irq <= |(status & mask);
   end
`endif
endmodule
